fifo_rr_arbiter: RTL and testbench
==================================

Name: fifo_rr_arbiter

Overview:
- Round-robin read scheduler that drains four request FIFOs (fifo_sc instances, 1-cycle read latency, valid-qualified dout) into one shared downstream FIFO.
- Used in the decoder to share a single memory-request path between independent producers, such as motion compensation reads, frame store writes and display reads.
- Grants one source at a time for a bounded burst and honours downstream prog_full back-pressure.

Parameters:
- dta_width, 64, width of each request word.
- burst_len, 8, maximum reads granted to one source per grant (1..255).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-low reset.
- src_empty  input  4  empty flags of source FIFOs; bit i is source i.
- src_valid  input  4  valid flags of source FIFOs; asserted the cycle after a successful read.
- src_dout  input  4*dta_width  source data; source i occupies bits [i*dta_width +: dta_width].
- src_rd_en  output  4  read enables to the sources; at most one bit is set.
- dst_prog_full  input  1  prog_full of the downstream FIFO.
- dst_din  output  dta_width  data to the downstream FIFO.
- dst_wr_en  output  1  write enable to the downstream FIFO.
- dst_src  output  2  index of the source that produced dst_din; valid with dst_wr_en.
- busy  output  1  high while in GRANT or while read data is still in flight.
- error  output  1  sticky; set on a protocol violation.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state=IDLE, rr_ptr=3 (so source 0 wins first), burst_cnt=0, rd_port=0.
  - dst_wr_en=0, dst_din=0, dst_src=0, error=0, busy=0, src_rd_en=0.
  - Reset mid-burst drops any in-flight word: no dst_wr_en in the cycle following reset.
- States are IDLE and GRANT.
- IDLE:
  - If dst_prog_full=0 and any src_empty bit is 0, select the first non-empty source scanning rr_ptr+1, rr_ptr+2, ... modulo 4.
  - Register it as grant, clear burst_cnt and go to GRANT.
  - Otherwise stay in IDLE.
  - src_rd_en=0 in IDLE, so there is always a one-cycle gap between grants.
- GRANT read enable:
  - src_rd_en[grant] is combinational: ~src_empty[grant] & ~dst_prog_full & (burst_cnt < burst_len).
  - All other bits are 0.
  - Each asserted read increments burst_cnt (8-bit) and loads rd_port<=grant.
- GRANT exit:
  - GRANT→IDLE when src_empty[grant]=1, or dst_prog_full=1, or burst_cnt reaches burst_len.
  - On exit, rr_ptr<=grant.
  - A read issued in the same cycle as the exit condition is still counted and its data still forwarded.
- Data path, registered:
  - dst_wr_en <= src_valid[rd_port].
  - dst_din <= src_dout slice [rd_port].
  - dst_src <= rd_port.
  - Latency is src_rd_en at cycle n → src_valid at n+1 → dst_wr_en at n+2.
  - dst_din and dst_src hold their value when dst_wr_en=0.
- In-flight data:
  - Up to 2 words are in flight after prog_full rises.
  - The downstream FIFO's prog_thresh must be ≥3; this is a system constraint, not checked here.
- busy = (state==GRANT) | (src_rd_en registered one cycle earlier) | dst_wr_en pending.
- error is set (sticky until reset) on either condition:
  - any src_valid bit other than rd_port is asserted;
  - src_valid[rd_port] is asserted without a read issued in the previous cycle.
- Starvation:
  - A source is never skipped while non-empty when its turn comes.
  - Worst-case wait is 3 × (burst_len + 2) cycles while back-pressure is absent.
- Simultaneous events:
  - Reset dominates everything.
  - dst_prog_full and burst completion in the same cycle produce a single exit; rr_ptr advances normally.

Test Plan:
- Single source, sustained: source 2 holds 20 words, burst_len=8, no back-pressure → bursts of 8, 8, 4 with a 1-cycle IDLE gap between them; dst_src=2 throughout; first dst_wr_en arrives 3 cycles after the first non-empty IDLE cycle; data order is preserved.
- Round robin: all four sources hold 16 words → grant order 0,1,2,3,0,1,2,3; each grant is exactly 8 words; 64 words total with dst_src tagging correct.
- Back-pressure: dst_prog_full rises mid-burst after 3 reads → src_rd_en drops the same cycle; at most 2 more dst_wr_en follow; state goes to IDLE; when prog_full clears, the next non-empty source after the interrupted one is granted.
- Early empty: source 1 holds 3 words, source 3 holds 5 → burst of 3 from source 1, IDLE, then burst of 5 from source 3; no underflow and no error.
- Reset mid-burst: rst=0 for 1 cycle during a source 0 burst → the next cycle shows dst_wr_en=0, src_rd_en=0, busy=0; after release, source 0 wins first again (rr_ptr=3).
- Protocol error: inject src_valid[2]=1 while idle → error=1 from the next cycle and it stays 1 until reset.

Source files
------------

// File: rtl/fifo_rr_arbiter.sv
// Round-robin burst scheduler that drains four request FIFOs
// into one shared downstream FIFO, honouring prog_full.
module fifo_rr_arbiter #(
  parameter int dta_width = 64,
  parameter int burst_len = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             src_empty,
  input  logic [3:0]             src_valid,
  input  logic [4*dta_width-1:0] src_dout,
  output logic [3:0]             src_rd_en,
  input  logic                   dst_prog_full,
  output logic [dta_width-1:0]   dst_din,
  output logic                   dst_wr_en,
  output logic [1:0]             dst_src,
  output logic                   busy,
  output logic                   error
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] BL = 8'(burst_len);

  state_t     state;
  state_t     state_nxt;
  logic [1:0] grant;
  logic [1:0] rr_ptr;
  logic [1:0] rd_port;
  logic [1:0] pick;
  logic [7:0] burst_cnt;
  logic [7:0] cnt_nxt;
  logic       rd;
  logic       rd_q;
  logic       any_req;
  logic       exit_g;
  logic       viol;
  logic [3:0] other_v;

  assign any_req = ~&src_empty;

  // scan downwards so the source nearest rr_ptr+1 wins
  always_comb begin
    pick = rr_ptr;
    for (int k = 4; k >= 1; k--) begin
      if (!src_empty[rr_ptr + 2'(k)])
        pick = rr_ptr + 2'(k);
    end
  end

  assign rd = (state == GRANT) & rst
            & ~src_empty[grant]
            & ~dst_prog_full
            & (burst_cnt < BL);

  assign src_rd_en = rd ? (4'b0001 << grant) : 4'b0000;
  assign cnt_nxt   = burst_cnt + {7'd0, rd};

  // the read of this cycle counts toward the burst limit
  assign exit_g = src_empty[grant]
                | dst_prog_full
                | (cnt_nxt >= BL);

  assign other_v = src_valid & ~(4'b0001 << rd_port);
  assign viol    = (|other_v)
                 | (src_valid[rd_port] & ~rd_q);

  assign busy = (state == GRANT) | rd_q | dst_wr_en;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (!dst_prog_full && any_req)
          state_nxt = GRANT;
      GRANT:
        if (exit_g)
          state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= 2'd3;
      burst_cnt <= '0;
      rd_port   <= '0;
      rd_q      <= 1'b0;
      dst_wr_en <= 1'b0;
      dst_din   <= '0;
      dst_src   <= '0;
      error     <= 1'b0;
    end else begin
      state     <= state_nxt;
      rd_q      <= rd;
      error     <= error | viol;
      dst_wr_en <= src_valid[rd_port];
      if (src_valid[rd_port]) begin
        dst_din <= src_dout[rd_port*dta_width +: dta_width];
        dst_src <= rd_port;
      end
      if (state == IDLE) begin
        if (state_nxt == GRANT) begin
          grant     <= pick;
          burst_cnt <= '0;
        end
      end else begin
        burst_cnt <= cnt_nxt;
        if (rd)
          rd_port <= grant;
        if (exit_g)
          rr_ptr <= grant;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// Bench for fifo_rr_arbiter: queue-based source FIFOs,
// burst-level round-robin reference and data scoreboard.
module tb_fifo_rr_arbiter;

  localparam int W  = 64;
  localparam int BL = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [3:0]   src_empty = 4'hf;
  logic [3:0]   src_valid;
  logic [3:0]   vmod = 4'h0;
  logic [3:0]   inj = 4'h0;
  logic [4*W-1:0] src_dout = '0;
  logic [3:0]   src_rd_en;
  logic         dst_prog_full = 1'b0;
  logic [W-1:0] dst_din;
  logic         dst_wr_en;
  logic [1:0]   dst_src;
  logic         busy;
  logic         error;

  assign src_valid = vmod | inj;

  always #5 clk = ~clk;

  fifo_rr_arbiter #(.dta_width(W), .burst_len(BL)) dut (
    .clk(clk), .rst(rst),
    .src_empty(src_empty), .src_valid(src_valid),
    .src_dout(src_dout), .src_rd_en(src_rd_en),
    .dst_prog_full(dst_prog_full), .dst_din(dst_din),
    .dst_wr_en(dst_wr_en), .dst_src(dst_src),
    .busy(busy), .error(error)
  );

  logic [W-1:0] q[4][$];
  logic [W-1:0] exp_q[4][$];
  int           wr_src[$];
  logic [W-1:0] wr_data[$];
  int           wr_cyc[$];
  int           exp_seq[$];
  int           cyc = 0;
  int           rd_bad = 0;
  int           pf_bad = 0;
  logic [1:0]   pf_hist = 2'b00;
  int           checks = 0;
  int           errors = 0;

  // source FIFOs: one-cycle read latency, registered empty
  always @(posedge clk) begin
    cyc     <= cyc + 1;
    pf_hist <= {pf_hist[0], dst_prog_full};
    if ($countones(src_rd_en) > 1) rd_bad <= rd_bad + 1;
    for (int i = 0; i < 4; i++) begin
      if (src_rd_en[i] && q[i].size() > 0) begin
        vmod[i] <= 1'b1;
        src_dout[i*W +: W] <= q[i].pop_front();
      end else begin
        vmod[i] <= 1'b0;
        if (src_rd_en[i]) rd_bad <= rd_bad + 1;
      end
      src_empty[i] <= (q[i].size() == 0);
    end
  end

  always @(posedge clk) begin
    #1;
    if (dst_wr_en) begin
      wr_src.push_back(int'(dst_src));
      wr_data.push_back(dst_din);
      wr_cyc.push_back(cyc);
      if (pf_hist[1]) pf_bad++;
    end
  end

  task automatic push(input int s, input int n);
    logic [W-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = {$urandom, $urandom};
      q[s].push_back(d);
      exp_q[s].push_back(d);
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b0;
    dst_prog_full = 1'b0;
    inj = 4'h0;
    @(negedge clk);
    rst = 1'b1;
    wr_src.delete();
    wr_data.delete();
    wr_cyc.delete();
  endtask

  // burst-level round robin: whole bursts, not cycles
  task automatic build_seq(input int c0, input int c1,
                           input int c2, input int c3,
                           input int ptr);
    int cnt[4];
    int p, s, n, left;
    cnt = '{c0, c1, c2, c3};
    p = ptr;
    exp_seq.delete();
    left = c0 + c1 + c2 + c3;
    while (left > 0) begin
      s = p;
      for (int k = 1; k <= 4; k++) begin
        if (cnt[(p + k) % 4] > 0) begin
          s = (p + k) % 4;
          break;
        end
      end
      n = (cnt[s] < BL) ? cnt[s] : BL;
      for (int k = 0; k < n; k++) exp_seq.push_back(s);
      cnt[s] -= n;
      left -= n;
      p = s;
    end
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    int quiet;
    quiet = 0;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (q[0].size() == 0 && q[1].size() == 0 &&
          q[2].size() == 0 && q[3].size() == 0 &&
          !busy && !dst_wr_en && src_empty == 4'hf)
        quiet++;
      else
        quiet = 0;
      if (quiet >= 3) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (dst_wr_en !== 1'b0 || src_rd_en !== 4'h0 ||
        busy !== 1'b0 || error !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl: wr=%b rd=%b busy=%b err=%b want 0",
               dst_wr_en, src_rd_en, busy, error);
    end
    checks++;
    if (dst_din !== '0 || dst_src !== 2'd0) begin
      errors++;
      $display("FAIL reset_data: din=%h src=%0d want 0",
               dst_din, dst_src);
    end
    rst = 1'b1;
  endtask

  task automatic test_single;
    int c_ne, c_wr, n, s, gap;
    bit ok;
    logic [W-1:0] ed;
    do_reset();
    push(2, 20);
    c_ne = -1;
    c_wr = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (c_ne < 0 && !src_empty[2] && !busy) c_ne = k;
      if (dst_wr_en) begin
        c_wr = k;
        break;
      end
    end
    checks++;
    if (c_ne < 0 || c_wr - c_ne !== 3) begin
      errors++;
      $display("FAIL single_latency: got %0d want 3",
               c_wr - c_ne);
    end
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL single_drain: timeout got 0 want 1");
    end
    build_seq(0, 0, 20, 0, 3);
    checks++;
    if (wr_src.size() !== exp_seq.size()) begin
      errors++;
      $display("FAIL single_count: got %0d want %0d",
               wr_src.size(), exp_seq.size());
    end
    n = (wr_src.size() < exp_seq.size()) ?
        wr_src.size() : exp_seq.size();
    for (int k = 0; k < n; k++) begin
      s = exp_seq[k];
      ed = exp_q[s].pop_front();
      checks++;
      if (wr_src[k] !== s || wr_data[k] !== ed) begin
        errors++;
        $display("FAIL single_word[%0d]: src %0d data %h want %0d %h",
                 k, wr_src[k], wr_data[k], s, ed);
      end
      if (k > 0) begin
        gap = (k % BL == 0) ? 2 : 1;
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] !== gap) begin
          errors++;
          $display("FAIL single_gap[%0d]: got %0d want %0d",
                   k, wr_cyc[k] - wr_cyc[k-1], gap);
        end
      end
    end
  endtask

  task automatic test_round_robin;
    int n, s, gap;
    bit ok;
    logic [W-1:0] ed;
    do_reset();
    for (int i = 0; i < 4; i++) push(i, 16);
    wait_idle(600, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_drain: timeout got 0 want 1");
    end
    build_seq(16, 16, 16, 16, 3);
    checks++;
    if (wr_src.size() !== 64) begin
      errors++;
      $display("FAIL rr_count: got %0d want 64", wr_src.size());
    end
    n = (wr_src.size() < exp_seq.size()) ?
        wr_src.size() : exp_seq.size();
    for (int k = 0; k < n; k++) begin
      s = exp_seq[k];
      ed = exp_q[s].pop_front();
      checks++;
      if (wr_src[k] !== s || wr_data[k] !== ed) begin
        errors++;
        $display("FAIL rr_word[%0d]: src %0d data %h want %0d %h",
                 k, wr_src[k], wr_data[k], s, ed);
      end
      if (k > 0) begin
        gap = (k % BL == 0) ? 2 : 1;
        checks++;
        if (wr_cyc[k] - wr_cyc[k-1] !== gap) begin
          errors++;
          $display("FAIL rr_gap[%0d]: got %0d want %0d",
                   k, wr_cyc[k] - wr_cyc[k-1], gap);
        end
      end
    end
  endtask

  task automatic test_back_pressure;
    int rd_seen, base, n, s;
    bit ok;
    logic [W-1:0] ed;
    do_reset();
    push(0, 10);
    push(1, 4);
    rd_seen = 0;
    for (int k = 0; k < 40 && rd_seen < 3; k++) begin
      @(negedge clk);
      if (src_rd_en[0]) rd_seen++;
    end
    checks++;
    if (rd_seen !== 3) begin
      errors++;
      $display("FAIL bp_reads: got %0d want 3", rd_seen);
    end
    @(negedge clk);
    dst_prog_full = 1'b1;
    base = wr_src.size();
    #1;
    checks++;
    if (src_rd_en !== 4'h0) begin
      errors++;
      $display("FAIL bp_rd_drop: got %b want 0000", src_rd_en);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (wr_src.size() - base > 2) begin
      errors++;
      $display("FAIL bp_inflight: got %0d want <=2",
               wr_src.size() - base);
    end
    checks++;
    if (busy !== 1'b0 || src_rd_en !== 4'h0) begin
      errors++;
      $display("FAIL bp_idle: busy %b rd %b want 0 0000",
               busy, src_rd_en);
    end
    dst_prog_full = 1'b0;
    wait_idle(400, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: timeout got 0 want 1");
    end
    build_seq(7, 4, 0, 0, 0);
    for (int k = 0; k < 3; k++) exp_seq.push_front(0);
    checks++;
    if (wr_src.size() !== exp_seq.size()) begin
      errors++;
      $display("FAIL bp_count: got %0d want %0d",
               wr_src.size(), exp_seq.size());
    end
    n = (wr_src.size() < exp_seq.size()) ?
        wr_src.size() : exp_seq.size();
    for (int k = 0; k < n; k++) begin
      s = exp_seq[k];
      ed = exp_q[s].pop_front();
      checks++;
      if (wr_src[k] !== s || wr_data[k] !== ed) begin
        errors++;
        $display("FAIL bp_word[%0d]: src %0d data %h want %0d %h",
                 k, wr_src[k], wr_data[k], s, ed);
      end
    end
  endtask

  task automatic test_early_empty;
    int n, s;
    bit ok;
    logic [W-1:0] ed;
    do_reset();
    push(1, 3);
    push(3, 5);
    wait_idle(300, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL ee_drain: timeout got 0 want 1");
    end
    build_seq(0, 3, 0, 5, 3);
    checks++;
    if (wr_src.size() !== 8) begin
      errors++;
      $display("FAIL ee_count: got %0d want 8", wr_src.size());
    end
    n = (wr_src.size() < exp_seq.size()) ?
        wr_src.size() : exp_seq.size();
    for (int k = 0; k < n; k++) begin
      s = exp_seq[k];
      ed = exp_q[s].pop_front();
      checks++;
      if (wr_src[k] !== s || wr_data[k] !== ed) begin
        errors++;
        $display("FAIL ee_word[%0d]: src %0d data %h want %0d %h",
                 k, wr_src[k], wr_data[k], s, ed);
      end
    end
    checks++;
    if (error !== 1'b0 || rd_bad !== 0) begin
      errors++;
      $display("FAIL ee_error: err %b rd_bad %0d want 0 0",
               error, rd_bad);
    end
  endtask

  task automatic test_reset_mid_burst;
    int base;
    bit ok;
    logic [W-1:0] head;
    do_reset();
    push(0, 12);
    push(1, 4);
    for (int k = 0; k < 40 && wr_src.size() < 4; k++)
      @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (dst_wr_en !== 1'b0 || src_rd_en !== 4'h0 ||
        busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: wr %b rd %b busy %b want 0",
               dst_wr_en, src_rd_en, busy);
    end
    rst = 1'b1;
    head = q[0][0];
    base = wr_src.size();
    for (int k = 0; k < 40 && wr_src.size() <= base; k++)
      @(negedge clk);
    checks++;
    if (wr_src.size() <= base) begin
      errors++;
      $display("FAIL mid_restart: timeout got 0 want 1");
    end else if (wr_src[base] !== 0 || wr_data[base] !== head) begin
      errors++;
      $display("FAIL mid_restart: src %0d data %h want 0 %h",
               wr_src[base], wr_data[base], head);
    end
    wait_idle(300, ok);
    checks++;
    if (!ok || error !== 1'b0) begin
      errors++;
      $display("FAIL mid_drain: ok %b err %b want 1 0", ok, error);
    end
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  task automatic test_protocol_error;
    do_reset();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL perr_pre: got %b want 0", error);
    end
    inj = 4'b0100;
    @(negedge clk);
    inj = 4'b0000;
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL perr_set: got %b want 1", error);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (error !== 1'b1) begin
      errors++;
      $display("FAIL perr_sticky: got %b want 1", error);
    end
    do_reset();
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL perr_clear: got %b want 0", error);
    end
  endtask

  task automatic test_random;
    int pushed, s;
    bit ok;
    do_reset();
    pushed = 0;
    for (int k = 0; k < 800; k++) begin
      @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, 3);
        push(s, $urandom_range(1, 4));
        pushed = exp_q[0].size() + exp_q[1].size()
               + exp_q[2].size() + exp_q[3].size();
      end
      if ($urandom_range(0, 9) == 0)
        dst_prog_full = ~dst_prog_full;
    end
    dst_prog_full = 1'b0;
    wait_idle(3000, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rand_drain: timeout got 0 want 1");
    end
    checks++;
    if (wr_src.size() !== pushed) begin
      errors++;
      $display("FAIL rand_count: got %0d want %0d",
               wr_src.size(), pushed);
    end
    for (int k = 0; k < wr_src.size(); k++) begin
      s = wr_src[k];
      checks++;
      if (exp_q[s].size() == 0) begin
        errors++;
        $display("FAIL rand_word[%0d]: src %0d got data want none",
                 k, s);
      end else if (wr_data[k] !== exp_q[s][0]) begin
        errors++;
        $display("FAIL rand_word[%0d]: data %h want %h",
                 k, wr_data[k], exp_q[s][0]);
        void'(exp_q[s].pop_front());
      end else begin
        void'(exp_q[s].pop_front());
      end
    end
    checks++;
    if (rd_bad !== 0 || pf_bad !== 0 || error !== 1'b0) begin
      errors++;
      $display("FAIL rand_proto: rd_bad %0d pf_bad %0d err %b want 0",
               rd_bad, pf_bad, error);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_early_empty();
    test_reset_mid_burst();
    test_protocol_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
